// File: rtl/pdp8_exec_unit.sv
// PDP-8 execute stage: memory-reference ops and OPR group 1/2 microcode with req/ack memory handshakes.
// Optional PDP8_EXEC_OSR_EN adds the sw_reg port and the group 2 OSR microbit.
module pdp8_exec_unit #(
  parameter int DATA_WIDTH  = 12,
  parameter int ADDR_WIDTH  = 12,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic                  instr_valid,
  input  logic [DATA_WIDTH-1:0] instr,
  input  logic [ADDR_WIDTH-1:0] eff_addr,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] pc_value,
  output logic [DATA_WIDTH-1:0] ac_value,
  output logic                  link_value,
  output logic                  halted,
  output logic                  err_timeout,
`ifdef PDP8_EXEC_OSR_EN
  input  logic [DATA_WIDTH-1:0] sw_reg,
`endif
  output logic                  rd_req,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic                  rd_ack,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic                  wr_req,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_ack
);

  localparam int TW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [TW-1:0]         TMO_LAST = TW'(MEM_TIMEOUT - 1);
  localparam logic [TW-1:0]         TMO_ONE  = TW'(1);
  localparam logic [ADDR_WIDTH-1:0] ONE_A    = ADDR_WIDTH'(1);
  localparam logic [DATA_WIDTH-1:0] ONE_D    = DATA_WIDTH'(1);

  localparam logic [2:0] OP_AND = 3'd0;
  localparam logic [2:0] OP_TAD = 3'd1;
  localparam logic [2:0] OP_ISZ = 3'd2;
  localparam logic [2:0] OP_DCA = 3'd3;
  localparam logic [2:0] OP_JMS = 3'd4;
  localparam logic [2:0] OP_JMP = 3'd5;
  localparam logic [2:0] OP_OPR = 3'd7;

  typedef enum logic [2:0] {
    S_INIT, S_WAIT, S_DISPATCH, S_RD_WAIT, S_WR_WAIT, S_RETIRE, S_HALT, S_ERR
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d, pcw_q, pcw_d, ea_q, ea_d;
  logic [DATA_WIDTH-1:0] ac_q, ac_d, acw_q, acw_d, ir_q, ir_d, wdata_q, wdata_d;
  logic                  link_q, link_d, lnw_q, lnw_d, hlt_q, hlt_d;
  logic [TW-1:0]         tmo_q, tmo_d;

  logic [2:0]            opcode;
  logic [8:0]            mb;
  logic [ADDR_WIDTH-1:0] pc_inc;
  logic [DATA_WIDTH:0]   lac_g1;
  logic                  skip_g2;
  logic [DATA_WIDTH-1:0] osr_val, ac_g2, isz_v;
  logic [DATA_WIDTH:0]   tad_sum;

  // Group 1: clear, complement, increment, then rotate the {LINK,AC} word.
  function automatic logic [DATA_WIDTH:0] opr_group1(input logic [DATA_WIDTH:0] lac_in,
                                                     input logic [8:0] bits);
    logic [DATA_WIDTH:0] r;
    logic [DATA_WIDTH:0] inc;
    r = lac_in;
    if (bits[7]) r[DATA_WIDTH-1:0] = '0;
    if (bits[6]) r[DATA_WIDTH] = 1'b0;
    if (bits[5]) r[DATA_WIDTH-1:0] = ~r[DATA_WIDTH-1:0];
    if (bits[4]) r[DATA_WIDTH] = ~r[DATA_WIDTH];
    if (bits[0]) begin
      inc = {1'b0, r[DATA_WIDTH-1:0]} + {{DATA_WIDTH{1'b0}}, 1'b1};
      r   = {r[DATA_WIDTH] ^ inc[DATA_WIDTH], inc[DATA_WIDTH-1:0]};
    end
    if (bits[3] ^ bits[2]) begin
      for (int i = 0; i < 2; i++) begin
        if (i == 0 || bits[1])
          r = bits[3] ? {r[0], r[DATA_WIDTH:1]} : {r[DATA_WIDTH-1:0], r[DATA_WIDTH]};
      end
    end
    return r;
  endfunction

  // Reverse-sense skip (bit3) is the exact complement of the OR of selected conditions.
  function automatic logic opr_group2_skip(input logic signed [DATA_WIDTH-1:0] ac,
                                           input logic link, input logic [8:0] bits);
    logic any;
    any = (bits[6] & (ac < 0)) | (bits[5] & (ac == '0)) | (bits[4] & link);
    return bits[3] ? ~any : any;
  endfunction

  assign opcode  = ir_q[DATA_WIDTH-1 -: 3];
  assign mb      = ir_q[8:0];
  assign pc_inc  = pc_q + ONE_A;
  assign lac_g1  = opr_group1({link_q, ac_q}, mb);
  assign skip_g2 = opr_group2_skip(ac_q, link_q, mb);
`ifdef PDP8_EXEC_OSR_EN
  assign osr_val = mb[2] ? sw_reg : '0;
`else
  assign osr_val = '0;
`endif
  assign ac_g2   = (mb[7] ? '0 : ac_q) | osr_val;
  assign isz_v   = rd_data + ONE_D;
  assign tad_sum = {1'b0, acw_q} + {1'b0, rd_data};

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ac_d    = ac_q;
    link_d  = link_q;
    pcw_d   = pcw_q;
    acw_d   = acw_q;
    lnw_d   = lnw_q;
    ir_d    = ir_q;
    ea_d    = ea_q;
    wdata_d = wdata_q;
    hlt_d   = hlt_q;
    tmo_d   = '0;
    case (state_q)
      S_INIT: begin
        pc_d    = base_addr;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (instr_valid) begin
          ir_d    = instr;
          ea_d    = eff_addr;
          state_d = S_DISPATCH;
        end
      end
      S_DISPATCH: begin
        pcw_d   = pc_inc;
        acw_d   = ac_q;
        lnw_d   = link_q;
        hlt_d   = 1'b0;
        state_d = S_RETIRE;
        case (opcode)
          OP_AND, OP_TAD, OP_ISZ: state_d = S_RD_WAIT;
          OP_DCA: begin
            wdata_d = ac_q;
            state_d = S_WR_WAIT;
          end
          OP_JMS: begin
            wdata_d = DATA_WIDTH'(pc_inc);
            state_d = S_WR_WAIT;
          end
          OP_JMP: pcw_d = ea_q;
          OP_OPR: begin
            if (!mb[8]) begin
              {lnw_d, acw_d} = lac_g1;
            end else if (!mb[0]) begin
              if (skip_g2) pcw_d = pc_inc + ONE_A;
              acw_d = ac_g2;
              hlt_d = mb[1];
            end
          end
          default: ;
        endcase
      end
      S_RD_WAIT: begin
        if (rd_ack) begin
          state_d = S_RETIRE;
          case (opcode)
            OP_AND: acw_d = acw_q & rd_data;
            OP_TAD: begin
              acw_d = tad_sum[DATA_WIDTH-1:0];
              lnw_d = lnw_q ^ tad_sum[DATA_WIDTH];
            end
            default: begin
              wdata_d = isz_v;
              if (isz_v == '0) pcw_d = pcw_q + ONE_A;
              state_d = S_WR_WAIT;
            end
          endcase
        end else if (tmo_q == TMO_LAST) begin
          state_d = S_ERR;
        end else begin
          tmo_d = tmo_q + TMO_ONE;
        end
      end
      S_WR_WAIT: begin
        if (wr_ack) begin
          state_d = S_RETIRE;
          if (opcode == OP_DCA) acw_d = '0;
          if (opcode == OP_JMS) pcw_d = ea_q + ONE_A;
        end else if (tmo_q == TMO_LAST) begin
          state_d = S_ERR;
        end else begin
          tmo_d = tmo_q + TMO_ONE;
        end
      end
      S_RETIRE: begin
        pc_d    = pcw_q;
        ac_d    = acw_q;
        link_d  = lnw_q;
        state_d = hlt_q ? S_HALT : S_WAIT;
      end
      S_HALT:  state_d = S_HALT;
      S_ERR:   state_d = S_ERR;
      default: state_d = S_ERR;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_INIT;
      pc_q    <= '0;
      ac_q    <= '0;
      link_q  <= 1'b0;
      pcw_q   <= '0;
      acw_q   <= '0;
      lnw_q   <= 1'b0;
      ir_q    <= '0;
      ea_q    <= '0;
      wdata_q <= '0;
      hlt_q   <= 1'b0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ac_q    <= ac_d;
      link_q  <= link_d;
      pcw_q   <= pcw_d;
      acw_q   <= acw_d;
      lnw_q   <= lnw_d;
      ir_q    <= ir_d;
      ea_q    <= ea_d;
      wdata_q <= wdata_d;
      hlt_q   <= hlt_d;
      tmo_q   <= tmo_d;
    end
  end

  assign busy        = (state_q != S_WAIT);
  assign halted      = (state_q == S_HALT);
  assign err_timeout = (state_q == S_ERR);
  assign rd_req      = (state_q == S_RD_WAIT);
  assign wr_req      = (state_q == S_WR_WAIT);
  assign rd_addr     = ea_q;
  assign wr_addr     = ea_q;
  assign wr_data     = wdata_q;
  assign pc_value    = pc_q;
  assign ac_value    = ac_q;
  assign link_value  = link_q;

endmodule

// File: tb/tb_pdp8_exec_unit.sv
// Directed, table-driven bench for pdp8_exec_unit: instruction vectors with a simple acking memory.
module tb_pdp8_exec_unit;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [11:0] base_addr = 12'o200;
  logic        instr_valid = 1'b0;
  logic [11:0] instr = '0;
  logic [11:0] eff_addr = '0;
  logic        busy, link_value, halted, err_timeout;
  logic [11:0] pc_value, ac_value;
  logic        rd_req, wr_req;
  logic [11:0] rd_addr, wr_addr, wr_data;
  logic        rd_ack = 1'b0, wr_ack = 1'b0;
  logic [11:0] rd_data = '0;
`ifdef PDP8_EXEC_OSR_EN
  logic [11:0] sw_reg = '0;
`endif

  int checks = 0;
  int failures = 0;

  pdp8_exec_unit dut (
    .clk(clk), .reset(reset), .base_addr(base_addr), .instr_valid(instr_valid),
    .instr(instr), .eff_addr(eff_addr), .busy(busy), .pc_value(pc_value),
    .ac_value(ac_value), .link_value(link_value), .halted(halted),
    .err_timeout(err_timeout),
`ifdef PDP8_EXEC_OSR_EN
    .sw_reg(sw_reg),
`endif
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack), .rd_data(rd_data),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0o expected %0o (octal)", name, act, exp);
    end
  endtask

  typedef struct {
    logic [11:0] ins;
    logic [11:0] ea;
    logic [11:0] mem;
    int          dly;
    logic [11:0] e_ac;
    logic        e_link;
    logic [11:0] e_pc;
    int          e_lat;
    logic        e_wr;
    logic [11:0] e_waddr;
    logic [11:0] e_wdata;
  } vec_t;

  vec_t vecs [28];

  // Presents one instruction at a negedge and plays memory until busy falls or HALT.
  task automatic run_instr(input logic [11:0] ins, input logic [11:0] ea, input logic [11:0] mem,
                           input int dly, output logic did_wr, output logic [11:0] waddr,
                           output logic [11:0] wdata, output int lat, output logic done);
    int rcnt, wcnt;
    rcnt = 0; wcnt = 0; lat = 0;
    did_wr = 1'b0; waddr = '0; wdata = '0; done = 1'b0;
    instr_valid = 1'b1; instr = ins; eff_addr = ea;
    @(negedge clk);
    instr_valid = 1'b0;
    for (int c = 0; c < 100; c++) begin
      rd_ack = 1'b0;
      wr_ack = 1'b0;
      if (!busy || halted) begin
        done = 1'b1;
        break;
      end
      lat++;
      if (rd_req) begin
        if (rcnt == dly) begin
          rd_ack  = 1'b1;
          rd_data = mem;
        end
        rcnt++;
      end
      if (wr_req) begin
        if (wcnt == dly) begin
          wr_ack = 1'b1;
          did_wr = 1'b1;
          waddr  = wr_addr;
          wdata  = wr_data;
        end
        wcnt++;
      end
      @(negedge clk);
    end
    rd_ack = 1'b0;
    wr_ack = 1'b0;
  endtask

  logic        v_wr, v_done;
  logic [11:0] v_waddr, v_wdata;
  int          v_lat, n;

  initial begin
    //        ins      ea       mem      dly  ac       l     pc       lat wr    waddr    wdata
    vecs[0]  = '{12'o7240, 12'o0000, 12'o0000, 0, 12'o7777, 1'b0, 12'o0201, 2, 1'b0, 12'o0000, 12'o0000};
    vecs[1]  = '{12'o1100, 12'o0100, 12'o0001, 0, 12'o0000, 1'b1, 12'o0202, 3, 1'b0, 12'o0000, 12'o0000};
    vecs[2]  = '{12'o2050, 12'o0050, 12'o7777, 1, 12'o0000, 1'b1, 12'o0204, 6, 1'b1, 12'o0050, 12'o0000};
    vecs[3]  = '{12'o2051, 12'o0051, 12'o0005, 0, 12'o0000, 1'b1, 12'o0205, 4, 1'b1, 12'o0051, 12'o0006};
    vecs[4]  = '{12'o7240, 12'o0000, 12'o0000, 0, 12'o7777, 1'b1, 12'o0206, 2, 1'b0, 12'o0000, 12'o0000};
    vecs[5]  = '{12'o0060, 12'o0060, 12'o5252, 2, 12'o5252, 1'b1, 12'o0207, 5, 1'b0, 12'o0000, 12'o0000};
    vecs[6]  = '{12'o3070, 12'o0070, 12'o0000, 3, 12'o0000, 1'b1, 12'o0210, 6, 1'b1, 12'o0070, 12'o5252};
    vecs[7]  = '{12'o7300, 12'o0000, 12'o0000, 0, 12'o0000, 1'b0, 12'o0211, 2, 1'b0, 12'o0000, 12'o0000};
    vecs[8]  = '{12'o7001, 12'o0000, 12'o0000, 0, 12'o0001, 1'b0, 12'o0212, 2, 1'b0, 12'o0000, 12'o0000};
    vecs[9]  = '{12'o7004, 12'o0000, 12'o0000, 0, 12'o0002, 1'b0, 12'o0213, 2, 1'b0, 12'o0000, 12'o0000};
    vecs[10] = '{12'o7012, 12'o0000, 12'o0000, 0, 12'o0000, 1'b1, 12'o0214, 2, 1'b0, 12'o0000, 12'o0000};
    vecs[11] = '{12'o7240, 12'o0000, 12'o0000, 0, 12'o7777, 1'b1, 12'o0215, 2, 1'b0, 12'o0000, 12'o0000};
    vecs[12] = '{12'o7001, 12'o0000, 12'o0000, 0, 12'o0000, 1'b0, 12'o0216, 2, 1'b0, 12'o0000, 12'o0000};
    vecs[13] = '{12'o7020, 12'o0000, 12'o0000, 0, 12'o0000, 1'b1, 12'o0217, 2, 1'b0, 12'o0000, 12'o0000};
    vecs[14] = '{12'o7014, 12'o0000, 12'o0000, 0, 12'o0000, 1'b1, 12'o0220, 2, 1'b0, 12'o0000, 12'o0000};
    vecs[15] = '{12'o5200, 12'o0200, 12'o0000, 0, 12'o0000, 1'b1, 12'o0200, 2, 1'b0, 12'o0000, 12'o0000};
    vecs[16] = '{12'o4300, 12'o0300, 12'o0000, 0, 12'o0000, 1'b1, 12'o0301, 3, 1'b1, 12'o0300, 12'o0201};
    vecs[17] = '{12'o7330, 12'o0000, 12'o0000, 0, 12'o4000, 1'b0, 12'o0302, 2, 1'b0, 12'o0000, 12'o0000};
    vecs[18] = '{12'o7700, 12'o0000, 12'o0000, 0, 12'o0000, 1'b0, 12'o0304, 2, 1'b0, 12'o0000, 12'o0000};
    vecs[19] = '{12'o7450, 12'o0000, 12'o0000, 0, 12'o0000, 1'b0, 12'o0305, 2, 1'b0, 12'o0000, 12'o0000};
    vecs[20] = '{12'o7440, 12'o0000, 12'o0000, 0, 12'o0000, 1'b0, 12'o0307, 2, 1'b0, 12'o0000, 12'o0000};
    vecs[21] = '{12'o7410, 12'o0000, 12'o0000, 0, 12'o0000, 1'b0, 12'o0311, 2, 1'b0, 12'o0000, 12'o0000};
    vecs[22] = '{12'o7420, 12'o0000, 12'o0000, 0, 12'o0000, 1'b0, 12'o0312, 2, 1'b0, 12'o0000, 12'o0000};
    vecs[23] = '{12'o6000, 12'o0000, 12'o0000, 0, 12'o0000, 1'b0, 12'o0313, 2, 1'b0, 12'o0000, 12'o0000};
    vecs[24] = '{12'o7401, 12'o0000, 12'o0000, 0, 12'o0000, 1'b0, 12'o0314, 2, 1'b0, 12'o0000, 12'o0000};
    vecs[25] = '{12'o5777, 12'o7777, 12'o0000, 0, 12'o0000, 1'b0, 12'o7777, 2, 1'b0, 12'o0000, 12'o0000};
    vecs[26] = '{12'o7000, 12'o0000, 12'o0000, 0, 12'o0000, 1'b0, 12'o0000, 2, 1'b0, 12'o0000, 12'o0000};
    vecs[27] = '{12'o7510, 12'o0000, 12'o0000, 0, 12'o0000, 1'b0, 12'o0002, 2, 1'b0, 12'o0000, 12'o0000};

    // Reset state and first PC load
    #2;
    check("rst busy", busy, 1);
    check("rst pc", pc_value, 0);
    check("rst ac", ac_value, 0);
    check("rst link", link_value, 0);
    check("rst reqs", {halted, err_timeout, rd_req, wr_req}, 0);
    check("rst addr/data", {rd_addr, wr_addr, wr_data}, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    check("init busy", busy, 1);
    @(negedge clk);
    check("init pc", pc_value, 12'o200);
    check("init busy low", busy, 0);

    for (int i = 0; i < 28; i++) begin
      run_instr(vecs[i].ins, vecs[i].ea, vecs[i].mem, vecs[i].dly, v_wr, v_waddr, v_wdata, v_lat, v_done);
      check($sformatf("v%0d done", i), v_done, 1);
      check($sformatf("v%0d ac", i), ac_value, vecs[i].e_ac);
      check($sformatf("v%0d link", i), link_value, vecs[i].e_link);
      check($sformatf("v%0d pc", i), pc_value, vecs[i].e_pc);
      check($sformatf("v%0d latency", i), v_lat, vecs[i].e_lat);
      check($sformatf("v%0d wrote", i), v_wr, vecs[i].e_wr);
      if (vecs[i].e_wr) begin
        check($sformatf("v%0d waddr", i), v_waddr, vecs[i].e_waddr);
        check($sformatf("v%0d wdata", i), v_wdata, vecs[i].e_wdata);
      end
    end

    // HLT: retires, then busy stays high and further instructions are ignored
    instr_valid = 1'b1; instr = 12'o7402; eff_addr = '0;
    @(negedge clk);
    instr_valid = 1'b0;
    n = 0;
    while (!halted && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("hlt halted", halted, 1);
    check("hlt cycles", n, 2);
    check("hlt pc", pc_value, 12'o0003);
    instr_valid = 1'b1; instr = 12'o7001;
    repeat (5) @(negedge clk);
    check("hlt busy", busy, 1);
    check("hlt ignores ac", ac_value, 0);
    check("hlt ignores pc", pc_value, 12'o0003);
    instr_valid = 1'b0;

    // Reset clears halt, then a read that never gets acked times out
    reset = 1'b1;
    #1;
    check("rst2 halted", halted, 0);
    check("rst2 pc", pc_value, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst2 busy", busy, 0);
    instr_valid = 1'b1; instr = 12'o0010; eff_addr = 12'o0010;
    @(negedge clk);
    instr_valid = 1'b0;
    n = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (rd_req) n++;
      if (err_timeout) break;
    end
    check("tmo cycles", n, 255);
    check("tmo err", err_timeout, 1);
    check("tmo reqs dropped", {rd_req, wr_req}, 0);
    check("tmo busy", busy, 1);

    // Reset in the middle of an outstanding read
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    instr_valid = 1'b1; instr = 12'o1020; eff_addr = 12'o0020;
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    check("mid rd_req", rd_req, 1);
    check("mid rd_addr", rd_addr, 12'o0020);
    reset = 1'b1;
    #1;
    check("mid rst rd_req", rd_req, 0);
    check("mid rst err", err_timeout, 0);
    check("mid rst pc/ac", {pc_value, ac_value}, 0);
    @(negedge clk);
    reset = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
